// File: rtl/audio_filt_pkg.sv
// Shared types, widths and helpers for the scheduled audio post-filter.
package audio_filt_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 27;
  localparam int HP_SHIFT = 8;

  typedef enum logic [2:0] {
    IDLE,
    LP_L,
    LP_R,
    HP_L,
    HP_R,
    DONE
  } fsm_state_e;

  typedef enum logic {
    ALU_LP,
    ALU_HP
  } alu_op_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    if (v < SAT_MIN) return {1'b1, {(SAMPLE_W-1){1'b0}}};
    return SAMPLE_W'(v);
  endfunction

endpackage

// File: rtl/audio_filter_sched_if.sv
// Mixer-side sample inputs and DAC-side filtered outputs of the filter sequencer.
interface audio_filter_sched_if;
  import audio_filt_pkg::*;

  logic signed [SAMPLE_W-1:0] left_in;
  logic signed [SAMPLE_W-1:0] right_in;
  logic                       bypass_lp;
  logic                       bypass_hp;
  logic signed [SAMPLE_W-1:0] left_out;
  logic signed [SAMPLE_W-1:0] right_out;
  logic                       out_valid;
  logic                       tick;

  modport master (
    output left_in, right_in, bypass_lp, bypass_hp,
    input  left_out, right_out, out_valid, tick
  );

  modport slave (
    input  left_in, right_in, bypass_lp, bypass_hp,
    output left_out, right_out, out_valid, tick
  );

endinterface

// File: rtl/audio_filt_alu.sv
// Combinational LP/HP step for one channel; the only multiplier in the filter chain.
module audio_filt_alu
  import audio_filt_pkg::*;
#(
  parameter int HP_COEF = 253
) (
  input  alu_op_e                    op,
  input  logic                       bypass,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [SAMPLE_W-1:0] xlp,
  input  logic signed [SAMPLE_W-1:0] xhp,
  input  logic signed [SAMPLE_W-1:0] yhp,
  output logic signed [SAMPLE_W-1:0] result,
  output logic signed [SAMPLE_W-1:0] xlp_nxt,
  output logic signed [SAMPLE_W-1:0] xhp_nxt,
  output logic signed [SAMPLE_W-1:0] yhp_nxt
);

  localparam logic signed [ACC_W-1:0] COEF = ACC_W'(HP_COEF);

  logic signed [SAMPLE_W:0]  lp_sum;
  logic signed [SAMPLE_W:0]  hp_diff;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_shr;

  always_comb begin
    lp_sum  = (SAMPLE_W+1)'(x) + (SAMPLE_W+1)'(xlp);
    hp_diff = (SAMPLE_W+1)'(x) - (SAMPLE_W+1)'(xhp);
    prod    = ACC_W'(yhp) * COEF;
    acc     = (ACC_W'(hp_diff) <<< HP_SHIFT) + prod;
    acc_shr = acc >>> HP_SHIFT;

    result  = x;
    xlp_nxt = xlp;
    xhp_nxt = xhp;
    yhp_nxt = yhp;

    // Filter history always advances, even when the stage itself is bypassed.
    unique case (op)
      ALU_LP: begin
        result  = bypass ? x : SAMPLE_W'(lp_sum >>> 2);
        xlp_nxt = x;
      end
      ALU_HP: begin
        result  = bypass ? x : sat16(acc_shr);
        xhp_nxt = x;
        yhp_nxt = result;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/audio_filter_sched.sv
// Sample-rate divider, capture and four-step schedule sharing one filter ALU between channels.
module audio_filter_sched
  import audio_filt_pkg::*;
#(
  parameter int CLK_DIV = 636,
  parameter int HP_COEF = 253
) (
  input logic                 clk,
  input logic                 rst_n,
  audio_filter_sched_if.slave bus
);

  if (CLK_DIV < 8) begin : g_bad_clk_div
    $error("audio_filter_sched: CLK_DIV must be at least 8");
  end
  if (HP_COEF < 0 || HP_COEF > 255) begin : g_bad_hp_coef
    $error("audio_filter_sched: HP_COEF must fit in 8 unsigned bits");
  end

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  fsm_state_e                 state;
  logic [CNT_W-1:0]           cnt;
  logic signed [SAMPLE_W-1:0] cap [2];
  logic signed [SAMPLE_W-1:0] lp  [2];
  logic signed [SAMPLE_W-1:0] xlp [2];
  logic signed [SAMPLE_W-1:0] xhp [2];
  logic signed [SAMPLE_W-1:0] yhp [2];
  logic signed [SAMPLE_W-1:0] hp_left;
  logic                       byp_lp;
  logic                       byp_hp;

  alu_op_e                    alu_op;
  logic                       alu_byp;
  logic                       ch;
  logic signed [SAMPLE_W-1:0] alu_x;
  logic signed [SAMPLE_W-1:0] alu_res;
  logic signed [SAMPLE_W-1:0] alu_xlp_nxt;
  logic signed [SAMPLE_W-1:0] alu_xhp_nxt;
  logic signed [SAMPLE_W-1:0] alu_yhp_nxt;

  assign bus.tick = (cnt == CNT_LAST);

  // Route the active channel's operand and history into the shared ALU.
  always_comb begin
    alu_op  = ALU_LP;
    alu_byp = byp_lp;
    ch      = 1'b0;
    alu_x   = cap[0];
    unique case (state)
      LP_R: begin
        ch    = 1'b1;
        alu_x = cap[1];
      end
      HP_L: begin
        alu_op  = ALU_HP;
        alu_byp = byp_hp;
        alu_x   = lp[0];
      end
      HP_R: begin
        alu_op  = ALU_HP;
        alu_byp = byp_hp;
        ch      = 1'b1;
        alu_x   = lp[1];
      end
      default: ;
    endcase
  end

  audio_filt_alu #(.HP_COEF(HP_COEF)) u_alu (
    .op      (alu_op),
    .bypass  (alu_byp),
    .x       (alu_x),
    .xlp     (xlp[ch]),
    .xhp     (xhp[ch]),
    .yhp     (yhp[ch]),
    .result  (alu_res),
    .xlp_nxt (alu_xlp_nxt),
    .xhp_nxt (alu_xhp_nxt),
    .yhp_nxt (alu_yhp_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      state   <= IDLE;
      byp_lp  <= 1'b0;
      byp_hp  <= 1'b0;
      hp_left <= '0;
      for (int i = 0; i < 2; i++) begin
        cap[i] <= '0;
        lp[i]  <= '0;
        xlp[i] <= '0;
        xhp[i] <= '0;
        yhp[i] <= '0;
      end
      bus.left_out  <= '0;
      bus.right_out <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      cnt           <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      bus.out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.tick) begin
            cap[0] <= bus.left_in;
            cap[1] <= bus.right_in;
            byp_lp <= bus.bypass_lp;
            byp_hp <= bus.bypass_hp;
            state  <= LP_L;
          end
        end
        LP_L, LP_R: begin
          lp[ch]  <= alu_res;
          xlp[ch] <= alu_xlp_nxt;
          state   <= (state == LP_L) ? LP_R : HP_L;
        end
        HP_L: begin
          hp_left <= alu_res;
          xhp[0]  <= alu_xhp_nxt;
          yhp[0]  <= alu_yhp_nxt;
          state   <= HP_R;
        end
        // Both channels land together so out_valid and the data are visible in DONE.
        HP_R: begin
          xhp[1]        <= alu_xhp_nxt;
          yhp[1]        <= alu_yhp_nxt;
          bus.left_out  <= hp_left;
          bus.right_out <= alu_res;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
